mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide sequencer for the single-cycle MIPS core. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle sequence.
- While it runs, it drives `busy` so the core's control unit can stall MFHI/MFLO and further mult/div issue.
- It also services MTHI/MTLO writes and serves HI/LO reads to the register-file writeback mux.

Parameters:
- width, 32, operand width and HI/LO width; the iteration count equals width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high. Clears all state.
- start  input  1  issue request; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  input  width  rs value (multiplicand or dividend).
- op_b  input  width  rt value (multiplier or divisor).
- mthi_en  input  1  write wr_data into HI.
- mtlo_en  input  1  write wr_data into LO.
- wr_data  input  width  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- div_by_zero  output  1  sticky flag for the last operation: a DIV/DIVU had a zero divisor.
- hi  output  width  HI register.
- lo  output  width  LO register.

Behaviour:
- Reset: asserting rst at any time, including mid-operation, forces:
  - state IDLE;
  - hi = lo = 0; busy = done = div_by_zero = 0;
  - iteration counter 0.
  The aborted operation leaves no trace.
- States: IDLE, RUN, FIX.
- IDLE, on a start=1 edge:
  - latch op;
  - latch |op_a| and |op_b| (absolute values for signed ops, raw values for unsigned ops);
  - latch the sign bits;
  - go to RUN with counter=0; busy=1 from this edge.
  - op_a/op_b may change afterwards without effect.
- RUN: one iteration per cycle; counter increments; after the edge where counter==width-1, go to FIX.
  - Multiply: shift-add on a 2*width unsigned accumulator.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
- FIX (one cycle), then IDLE:
  - apply sign correction and write hi/lo;
  - done=1 for exactly this cycle; busy falls at the same edge.
  - div_by_zero is updated here and cleared by the next start.
- Latency: start sampled at edge N → hi/lo valid and done high after edge N+width+1 (N+33 for width=32). busy is high for width+1 cycles.
- MULT/MULTU: {hi,lo} = full 2*width product.
  - MULT result is negated if the operand signs differ.
- DIV/DIVU: lo = quotient, hi = remainder.
  - DIV quotient is negated if the signs differ; the remainder takes the dividend's sign (truncating division).
  - -2^31 / -1 gives lo=0x80000000, hi=0; no trap.
- Divisor == 0: same latency; result hi=op_a (latched original value), lo=all ones, div_by_zero=1 with done.
- start while busy (RUN/FIX): ignored, no queueing.
- mthi_en/mtlo_en:
  - honoured only in IDLE: register updates at the next edge;
  - both asserted together write the same wr_data to both;
  - ignored while busy.
- start and mthi/mtlo asserted together in IDLE: start wins, the move is dropped.
- hi/lo hold their prior values throughout RUN; there are no intermediate values visible.
- op=DIV/MULT signedness uses bit 0 of op (0 = signed).

Test Plan:
- Reset, then MULT op_a=0xFFFFFFFD (-3), op_b=7 → after 33 cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then DIV -7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1; a following DIVU 100/7 → lo=14, hi=2, div_by_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. During this op, pulse start (MULTU 2×3) at cycle 5 and mthi_en with wr_data=0x1234 → both ignored; final values unchanged.
- In IDLE: mthi_en with wr_data=0xAAAA5555 → hi=0xAAAA5555. Next cycle: start+mtlo_en together → mtlo dropped, operation runs.
- Start MULTU 5×5, assert rst at RUN cycle 10 → immediately busy=0, hi=lo=0, state IDLE. A new start afterwards completes normally, giving lo=25.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Bus between the MIPS core and its multiply/divide unit: issue request,
// HI/LO move-to writes, status flags and the HI/LO read values.
interface mips_muldiv_if #(
  parameter int width = 32
);
  logic             start;
  logic [1:0]       op;
  logic [width-1:0] op_a;
  logic [width-1:0] op_b;
  logic             mthi_en;
  logic             mtlo_en;
  logic [width-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [width-1:0] hi;
  logic [width-1:0] lo;

  // Core side: issues operations and moves, reads results.
  modport master (
    output start, op, op_a, op_b, mthi_en, mtlo_en, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side: owns HI/LO and the status flags.
  modport slave (
    input  start, op, op_a, op_b, mthi_en, mtlo_en, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the MIPS HI/LO registers.
// Operands are reduced to magnitudes at issue, one shift-add or restoring
// divide step runs per cycle for `width` cycles, and a final FIX cycle
// applies the sign correction and commits HI/LO.
module mips_muldiv_unit #(
  parameter int width = 32
) (
  input logic          clk,
  input logic          rst,
  mips_muldiv_if.slave bus
);
  localparam int cnt_w = $clog2(width);
  localparam logic [cnt_w-1:0] last_iter = cnt_w'(width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             is_div;      // latched op[1]
  logic             neg_a;       // dividend / multiplicand was negative (signed ops only)
  logic             neg_b;
  logic [width-1:0] opnd;        // |a| for multiply, |b| (divisor) for divide
  logic [width-1:0] acc_hi;      // partial product high half / running remainder
  logic [width-1:0] acc_lo;      // multiplier bits / dividend bits becoming quotient
  logic [width-1:0] hi_reg;
  logic [width-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;

  logic             sign_a_in;
  logic             sign_b_in;
  logic [width-1:0] abs_a_in;
  logic [width-1:0] abs_b_in;
  logic [width:0]   mul_sum;
  logic [width:0]   div_shift;
  logic [width-1:0] div_diff;
  logic             div_ge;
  logic [2*width-1:0] prod_fix;
  logic [width-1:0] quo_fix;
  logic [width-1:0] rem_fix;

  // Two's-complement negate when requested.
  function automatic logic [width-1:0] cond_neg(input logic [width-1:0] v, input logic neg);
    cond_neg = neg ? -v : v;
  endfunction

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

  // Issue-time magnitudes, per-iteration step arithmetic and final sign fix-up.
  always_comb begin
    sign_a_in = ~bus.op[0] & bus.op_a[width-1];
    sign_b_in = ~bus.op[0] & bus.op_b[width-1];
    abs_a_in  = cond_neg(bus.op_a, sign_a_in);
    abs_b_in  = cond_neg(bus.op_b, sign_b_in);

    // Shift-add: add multiplicand to the high half when the current multiplier bit is set.
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {width{1'b0}})};

    // Restoring divide: bring down the next dividend bit and try to subtract the divisor.
    // When the subtraction succeeds the difference is below the divisor, so the low
    // width bits of the shifted value minus the divisor give it exactly.
    div_shift = {acc_hi, acc_lo[width-1]};
    div_diff  = div_shift[width-1:0] - opnd;
    div_ge    = (div_shift >= {1'b0, opnd});

    if (neg_a ^ neg_b) begin
      prod_fix = -{acc_hi, acc_lo};
    end else begin
      prod_fix = {acc_hi, acc_lo};
    end
    quo_fix = cond_neg(acc_lo, neg_a ^ neg_b);
    // Remainder follows the dividend sign; with a zero divisor the remainder
    // register ends up holding |a|, so this restores the original dividend.
    rem_fix = cond_neg(acc_hi, neg_a);
  end

  // Sequencer FSM with registered HI/LO, busy, done and divide-by-zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {cnt_w{1'b0}};
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      opnd     <= {width{1'b0}};
      acc_hi   <= {width{1'b0}};
      acc_lo   <= {width{1'b0}};
      hi_reg   <= {width{1'b0}};
      lo_reg   <= {width{1'b0}};
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Start takes priority over any simultaneous HI/LO move.
            is_div   <= bus.op[1];
            neg_a    <= sign_a_in;
            neg_b    <= sign_b_in;
            acc_hi   <= {width{1'b0}};
            if (bus.op[1]) begin
              acc_lo <= abs_a_in;
              opnd   <= abs_b_in;
            end else begin
              acc_lo <= abs_b_in;
              opnd   <= abs_a_in;
            end
            cnt      <= {cnt_w{1'b0}};
            busy_reg <= 1'b1;
            dbz_reg  <= 1'b0;
            state    <= RUN;
          end else begin
            if (bus.mthi_en) begin
              hi_reg <= bus.wr_data;
            end else begin
              hi_reg <= hi_reg;
            end
            if (bus.mtlo_en) begin
              lo_reg <= bus.wr_data;
            end else begin
              lo_reg <= lo_reg;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            if (div_ge) begin
              acc_hi <= div_diff;
              acc_lo <= {acc_lo[width-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[width-1:0];
              acc_lo <= {acc_lo[width-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[width:1];
            acc_lo <= {mul_sum[0], acc_lo[width-1:1]};
          end
          cnt <= cnt + {{(cnt_w-1){1'b0}}, 1'b1};
          if (cnt == last_iter) begin
            state <= FIX;
          end else begin
            state <= RUN;
          end
        end
        FIX: begin
          if (is_div) begin
            hi_reg <= rem_fix;
            if (opnd == {width{1'b0}}) begin
              lo_reg  <= {width{1'b1}};
              dbz_reg <= 1'b1;
            end else begin
              lo_reg  <= quo_fix;
              dbz_reg <= 1'b0;
            end
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
            dbz_reg          <= 1'b0;
          end
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          cnt      <= {cnt_w{1'b0}};
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          cnt      <= {cnt_w{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, hand-written
// corner sequences (intrusion while busy, HI/LO moves, reset mid-operation)
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;
  localparam int width = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_muldiv_if #(.width(width)) bus ();
  mips_muldiv_unit #(.width(width)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t        vecs[10];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: full-precision 64-bit arithmetic straight from the MIPS rules.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sb, p, q, r;
    sa = o[0] ? longint'({32'd0, a}) : longint'(signed'(a));
    sb = o[0] ? longint'({32'd0, b}) : longint'(signed'(b));
    z = 1'b0;
    if (!o[1]) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Issue one operation at a negedge and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int intrude, input bit with_mtlo, input string nm);
    int cycles;
    bit held;
    held = 1'b1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    if (with_mtlo) begin
      bus.mtlo_en = 1'b1;
      bus.wr_data = 32'h5A5A_5A5A;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mtlo_en = 1'b0;
    bus.op      = 2'($urandom_range(0, 3));
    bus.op_a    = $urandom;
    bus.op_b    = $urandom;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      if (bus.done !== 1'b0 || bus.hi !== model_hi || bus.lo !== model_lo) held = 1'b0;
      cycles++;
      if (cycles == intrude) begin
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.op_a    = 32'd2;
        bus.op_b    = 32'd3;
        bus.mthi_en = 1'b1;
        bus.wr_data = 32'h0000_1234;
      end else begin
        bus.start   = 1'b0;
        bus.mthi_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.start   = 1'b0;
    bus.mthi_en = 1'b0;
    check({nm, "_busy_cycles"}, 64'(cycles), 64'd33);
    check({nm, "_hold"}, {63'd0, held}, 64'd1);
    check({nm, "_done"}, {63'd0, bus.done}, 64'd1);
    check({nm, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
    check({nm, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
    check({nm, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, ed});
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    check({nm, "_idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  // Global time bound in case the DUT wedges outside a bounded loop.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    logic        rz;

    vecs[0] = '{op: 2'b00, a: 32'hFFFF_FFFD, b: 32'h0000_0007, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0};
    vecs[1] = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0};
    vecs[2] = '{op: 2'b10, a: 32'hFFFF_FFF9, b: 32'h0000_0002, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0};
    vecs[3] = '{op: 2'b11, a: 32'h0000_0064, b: 32'h0000_0000, hi: 32'h0000_0064, lo: 32'hFFFF_FFFF, dbz: 1'b1};
    vecs[4] = '{op: 2'b11, a: 32'h0000_0064, b: 32'h0000_0007, hi: 32'h0000_0002, lo: 32'h0000_000E, dbz: 1'b0};
    vecs[5] = '{op: 2'b00, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0000_0000, dbz: 1'b0};
    vecs[6] = '{op: 2'b10, a: 32'h0000_0007, b: 32'hFFFF_FFFE, hi: 32'h0000_0001, lo: 32'hFFFF_FFFD, dbz: 1'b0};
    vecs[7] = '{op: 2'b10, a: 32'hFFFF_FFFB, b: 32'h0000_0000, hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF, dbz: 1'b1};
    vecs[8] = '{op: 2'b00, a: 32'h0000_0007, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF9, dbz: 1'b0};
    vecs[9] = '{op: 2'b11, a: 32'hFFFF_FFFF, b: 32'h0000_0001, hi: 32'h0000_0000, lo: 32'hFFFF_FFFF, dbz: 1'b0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.op_a    = 32'd0;
    bus.op_b    = 32'd0;
    bus.mthi_en = 1'b0;
    bus.mtlo_en = 1'b0;
    bus.wr_data = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    rst = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
             -1, 1'b0, $sformatf("vec%0d", i));
    end

    // Overflow divide with a start and an MTHI arriving mid-run: both must be dropped.
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0,
           5, 1'b0, "div_ovf_intrude");

    // MTHI alone, then MTHI+MTLO together, in IDLE.
    bus.mthi_en = 1'b1;
    bus.wr_data = 32'hAAAA_5555;
    @(negedge clk);
    bus.mthi_en = 1'b0;
    check("mthi_hi", {32'd0, bus.hi}, 64'h0000_0000_AAAA_5555);
    check("mthi_lo_kept", {32'd0, bus.lo}, {32'd0, model_lo});
    model_hi = 32'hAAAA_5555;
    bus.mthi_en = 1'b1;
    bus.mtlo_en = 1'b1;
    bus.wr_data = 32'h1357_9BDF;
    @(negedge clk);
    bus.mthi_en = 1'b0;
    bus.mtlo_en = 1'b0;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, 64'h1357_9BDF_1357_9BDF);
    model_hi = 32'h1357_9BDF;
    model_lo = 32'h1357_9BDF;

    // Start together with MTLO: the move is dropped, the multiply runs.
    run_op(2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0,
           -1, 1'b1, "start_vs_mtlo");

    // Make HI/LO nonzero so the reset clear is visible, then abort a MULTU mid-run.
    run_op(2'b01, 32'h0001_0003, 32'h0001_0005, 32'h0000_0001, 32'h0008_000F, 1'b0,
           -1, 1'b0, "pre_reset");
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_abort_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_regs", {bus.hi, bus.lo}, 64'd0);
    check("abort_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    run_op(2'b01, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, -1, 1'b0, "after_abort");

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_model(ro, ra, rb, rh, rl, rz);
      run_op(ro, ra, rb, rh, rl, rz, -1, 1'b0, $sformatf("rnd%0d_op%0d", k, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
